// File: rtl/bus_arb_pkg.sv
// Shared definitions for the internal data bus arbiter.
package bus_arb_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_GRANT   = GRANT,
        ST_RELEASE = RELEASE
    } state_t;

    // Default bound on consecutive grant cycles per ownership
    localparam int MAX_HOLD_DEF = 16;

    // Requester indices on the down-sampling processor bus
    localparam int REQ_REGB = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_ALU  = 2;
    localparam int REQ_IO   = 3;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotating-priority selector: first set req bit at or above ptr, with wrap.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    // Scan N_REQ positions starting at ptr; the first hit wins
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: IDLE/GRANT/RELEASE sequencer with bounded hold and a
// one-cycle turnaround between owners. All outputs are registered.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int SEL_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] bus_sel,
    output logic             bus_en,
    output logic             timeout,
    output logic             busy
);

    state_t           state, state_d;
    logic [N_REQ-1:0] grant_d;
    logic [SEL_W-1:0] sel_d;
    logic             en_d, to_d, busy_d;
    logic [SEL_W-1:0] ptr, ptr_d;
    logic [7:0]       cnt, cnt_d;

    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;

    rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic; outputs are computed here and registered below
    always_comb begin
        state_d = state;
        grant_d = grant;
        sel_d   = bus_sel;
        en_d    = bus_en;
        to_d    = 1'b0;
        ptr_d   = ptr;
        cnt_d   = cnt;
        case (state)
            ST_GRANT: begin
                // bus_sel always names the owner while in GRANT
                if (!req[bus_sel]) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    en_d    = 1'b0;
                end else if (cnt == 8'(MAX_HOLD)) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    en_d    = 1'b0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: begin
                // IDLE and RELEASE both arbitrate
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    sel_d   = pick_idx;
                    en_d    = 1'b1;
                    cnt_d   = 8'd1;
                    ptr_d   = (pick_idx == SEL_W'(N_REQ-1)) ? '0 : pick_idx + SEL_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    en_d    = 1'b0;
                end
            end
        endcase
        busy_d = (state_d == ST_GRANT);
    end

    // State, pointer, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            bus_sel <= '0;
            bus_en  <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
            ptr     <= '0;
            cnt     <= 8'd0;
        end else begin
            state   <= state_d;
            grant   <= grant_d;
            bus_sel <= sel_d;
            bus_en  <= en_d;
            timeout <= to_d;
            busy    <= busy_d;
            ptr     <= ptr_d;
            cnt     <= cnt_d;
        end
    end

endmodule
